pe_sequencer: RTL and testbench

- Controller that sequences one PE through a full job:
  - accept weights and activations from an upstream valid/ready stream into a local buffer;
  - replay each set to the PE as a gap-free burst using the PE's load_en/load_done handshake;
  - issue one start per output, capture pe_out on each compute_done, and forward results on a valid/ready output.
- Sits between the cluster's data router and a single PE instance.

---
 rtl/pe_pkg.sv | 19 +
 rtl/pe_sequencer_rise_detect.sv | 11 +
 rtl/pe_sequencer.sv | 127 ++++++++++++
 tb/tb_pe_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared FSM encoding and default burst sizes for the PE sequencer
package pe_pkg;
  localparam int KERNEL_EDGE = 3;
  localparam int ACT_EDGE = 5;
  localparam int W_WORDS = KERNEL_EDGE ** 2;
  localparam int A_WORDS = ACT_EDGE ** 2;
  typedef enum logic [3:0] {
    IDLE,
    FILL_W,
    PUSH_W,
    WAIT_W,
    FILL_A,
    PUSH_A,
    WAIT_A,
    RUN_START,
    RUN_WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/pe_sequencer_rise_detect.sv
// rise_detect: one-cycle high on a 0->1 transition of d
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk) prev <= reset ? 1'b0 : d;
  assign rise = d & ~prev;
endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: buffers a job's weights/activations, bursts them into one PE and drains its results
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int KERNEL_SIZE = KERNEL_EDGE,
  parameter int ACT_SIZE = ACT_EDGE,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_start,
  input  logic [CNT_WIDTH-1:0]  cfg_num_out,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] pe_filt,
  output logic [DATA_WIDTH-1:0] pe_act,
  output logic                  pe_load_en_wght,
  output logic                  pe_load_en_act,
  output logic                  pe_start,
  input  logic [DATA_WIDTH-1:0] pe_out,
  input  logic                  pe_compute_done,
  input  logic                  pe_load_done_wght,
  input  logic                  pe_load_done_iact,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  job_done
);
  localparam int NW = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NA = ACT_SIZE * ACT_SIZE;
  localparam int IW = $clog2(NA + 1);
  state_t state;
  logic [DATA_WIDTH-1:0] mem [NA];
  logic [IW-1:0] wr_idx, rd_idx, wr_nxt, rd_nxt;
  logic [CNT_WIDTH-1:0] remaining;
  logic w_rise, a_rise, c_rise, beat, last_beat, last_push;
  rise_detect u_rise_w (.clk(clk), .reset(reset), .d(pe_load_done_wght), .rise(w_rise));
  rise_detect u_rise_a (.clk(clk), .reset(reset), .d(pe_load_done_iact), .rise(a_rise));
  rise_detect u_rise_c (.clk(clk), .reset(reset), .d(pe_compute_done), .rise(c_rise));
  assign beat = in_valid & in_ready;
  assign wr_nxt = wr_idx + 1'b1;
  assign rd_nxt = rd_idx + 1'b1;
  assign last_beat = beat & (wr_nxt == IW'(state == FILL_W ? NW : NA));
  assign last_push = rd_nxt == IW'(state == PUSH_W ? NW : NA);
  assign busy = state != IDLE;
  always_ff @(posedge clk) if (beat) mem[wr_idx] <= in_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_idx <= '0;
      rd_idx <= '0;
      remaining <= '0;
      in_ready <= 1'b0;
      pe_filt <= '0;
      pe_act <= '0;
      pe_load_en_wght <= 1'b0;
      pe_load_en_act <= 1'b0;
      pe_start <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      pe_load_en_wght <= 1'b0;
      pe_load_en_act <= 1'b0;
      pe_start <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (beat) wr_idx <= wr_nxt;
      case (state)
        IDLE: if (job_start && !job_done) begin
          remaining <= cfg_num_out;
          wr_idx <= '0;
          in_ready <= 1'b1;
          state <= FILL_W;
        end
        FILL_W, FILL_A: if (last_beat) begin
          in_ready <= 1'b0;
          rd_idx <= '0;
          if (state == FILL_W) begin
            pe_load_en_wght <= 1'b1;
            pe_filt <= mem[0];
            state <= PUSH_W;
          end else begin
            pe_load_en_act <= 1'b1;
            pe_act <= mem[0];
            state <= PUSH_A;
          end
        end
        PUSH_W: begin
          rd_idx <= rd_nxt;
          pe_filt <= last_push ? '0 : mem[rd_nxt];
          if (last_push) state <= WAIT_W;
        end
        PUSH_A: begin
          rd_idx <= rd_nxt;
          pe_act <= last_push ? '0 : mem[rd_nxt];
          if (last_push) state <= WAIT_A;
        end
        WAIT_W: if (w_rise) begin
          wr_idx <= '0;
          in_ready <= 1'b1;
          state <= FILL_A;
        end
        WAIT_A: if (a_rise) state <= RUN_START;
        RUN_START: if (remaining == '0) state <= DONE;
        else if (!out_valid) begin
          pe_start <= 1'b1;
          state <= RUN_WAIT;
        end
        RUN_WAIT: if (c_rise) begin
          out_data <= pe_out;
          out_valid <= 1'b1;
          remaining <= remaining - 1'b1;
          state <= RUN_START;
        end
        DONE: if (!out_valid) begin
          job_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_sequencer.sv
// tb_pe_sequencer: randomized jobs against a behavioural PE model and a convolution scoreboard
module tb_pe_sequencer;
  import pe_pkg::*;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic job_start = 1'b0;
  logic [7:0] cfg_num_out = '0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready;
  logic [DW-1:0] pe_filt, pe_act;
  logic pe_load_en_wght, pe_load_en_act, pe_start;
  logic [DW-1:0] pe_out = '0;
  logic pe_compute_done = 1'b0;
  logic pe_load_done_wght = 1'b0;
  logic pe_load_done_iact = 1'b0;
  logic out_valid;
  logic [DW-1:0] out_data;
  logic out_ready = 1'b1;
  logic busy, job_done;
  int vectors = 0, miscompares = 0;
  int n_start = 0, n_done = 0, n_ld_w = 0, n_ld_a = 0;
  int wcnt = -1, acnt = -1, lat = 0, n_comp = 0;
  logic clr = 1'b0;
  logic [DW-1:0] job_w [W_WORDS];
  logic [DW-1:0] job_a [A_WORDS];
  logic [DW-1:0] pe_w [W_WORDS];
  logic [DW-1:0] pe_a [A_WORDS];

  pe_sequencer dut (
    .clk(clk),
    .reset(reset),
    .job_start(job_start),
    .cfg_num_out(cfg_num_out),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .pe_filt(pe_filt),
    .pe_act(pe_act),
    .pe_load_en_wght(pe_load_en_wght),
    .pe_load_en_act(pe_load_en_act),
    .pe_start(pe_start),
    .pe_out(pe_out),
    .pe_compute_done(pe_compute_done),
    .pe_load_done_wght(pe_load_done_wght),
    .pe_load_done_iact(pe_load_done_iact),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy),
    .job_done(job_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dotp(input int n, input logic [DW-1:0] w [W_WORDS], input logic [DW-1:0] a [A_WORDS]);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < W_WORDS; i++) s = s + w[i] * a[(i + n) % A_WORDS];
    return s;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      wcnt = -1;
      acnt = -1;
      lat = 0;
      n_comp = 0;
      clr = 1'b0;
      pe_load_done_wght = 1'b0;
      pe_load_done_iact = 1'b0;
      pe_compute_done = 1'b0;
      pe_out = '0;
    end else begin
      if (pe_load_en_wght) begin
        wcnt = 0;
        n_comp = 0;
        pe_load_done_wght = 1'b0;
      end
      if (wcnt >= 0 && wcnt < W_WORDS) begin
        check("pe_filt", pe_filt, job_w[wcnt]);
        pe_w[wcnt] = pe_filt;
        wcnt++;
      end else begin
        check("pe_filt_idle", pe_filt, '0);
        if (wcnt >= W_WORDS && wcnt < W_WORDS + 2) wcnt++;
        if (wcnt == W_WORDS + 2) pe_load_done_wght = 1'b1;
      end
      if (pe_load_en_act) begin
        acnt = 0;
        pe_load_done_iact = 1'b0;
      end
      if (acnt >= 0 && acnt < A_WORDS) begin
        check("pe_act", pe_act, job_a[acnt]);
        pe_a[acnt] = pe_act;
        acnt++;
      end else begin
        check("pe_act_idle", pe_act, '0);
        if (acnt >= A_WORDS && acnt < A_WORDS + 2) acnt++;
        if (acnt == A_WORDS + 2) pe_load_done_iact = 1'b1;
      end
      if (pe_start) begin
        check("pe_start_busy", lat, 0);
        lat = $urandom_range(3, 7);
        clr = 1'b1;
      end else if (clr) begin
        pe_compute_done = 1'b0;
        clr = 1'b0;
      end
      if (lat > 0) begin
        lat--;
        pe_out = lat == 0 ? dotp(n_comp, pe_w, pe_a) : DW'($urandom);
        if (lat == 0) begin
          pe_compute_done = 1'b1;
          n_comp++;
        end
      end else if (pe_compute_done) pe_out = DW'($urandom);
    end
  end

  always @(negedge clk) if (!reset) begin
    if (pe_start) n_start++;
    if (job_done) n_done++;
    if (pe_load_en_wght) n_ld_w++;
    if (pe_load_en_act) n_ld_a++;
    if (in_ready) check("in_ready_quiet", {pe_load_en_wght, pe_load_en_act, pe_start, out_valid}, '0);
    if (!busy) check("idle_no_ready", in_ready, 0);
  end

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {in_ready, pe_load_en_wght, pe_load_en_act, pe_start, out_valid, busy, job_done}, '0);
    check({tag, "_pe"}, {pe_filt, pe_act}, '0);
    check({tag, "_out"}, out_data, '0);
  endtask

  task automatic stream_job(input int n, input bit bubble, input bit seq);
    int idx = 0;
    int cyc = 0;
    for (int i = 0; i < W_WORDS; i++) job_w[i] = seq ? DW'(i + 1) : DW'($urandom);
    for (int i = 0; i < A_WORDS; i++) job_a[i] = seq ? DW'(W_WORDS + 1 + i) : DW'($urandom);
    cfg_num_out = 8'(n);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    cfg_num_out = 8'($urandom);
    while (idx < W_WORDS + A_WORDS && cyc < 2000) begin
      in_valid = bubble ? cyc[0] : 1'b1;
      in_data = idx < W_WORDS ? job_w[idx] : job_a[idx - W_WORDS];
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_beats", idx, W_WORDS + A_WORDS);
  endtask

  task automatic run_job(input int n, input bit bubble, input bit seq, input int stall, input bit rnd, input bit poke);
    int got = 0;
    int cyc = 0;
    int s0 = n_start;
    int d0 = n_done;
    int lw0 = n_ld_w;
    int la0 = n_ld_a;
    bit stalled = 1'b0;
    stream_job(n, bubble, seq);
    while (!job_done && cyc < 5000) begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && stall > 0 && !stalled) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        repeat (stall) @(negedge clk);
        check("stall_data", out_data, dotp(0, job_w, job_a));
        check("stall_valid", out_valid, 1);
        check("stall_starts", n_start - s0, 1);
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        check("out_data", out_data, dotp(got, job_w, job_a));
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("job_done", job_done, 1);
    if (poke) begin
      cfg_num_out = 8'd1;
      job_start = 1'b1;
    end
    @(negedge clk);
    job_start = 1'b0;
    out_ready = 1'b1;
    check("idle_after_done", busy, 0);
    check("results", got, n);
    check("starts", n_start - s0, n);
    check("done_pulses", n_done - d0, 1);
    check("load_en_wght", n_ld_w - lw0, 1);
    check("load_en_act", n_ld_a - la0, 1);
  endtask

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);
    run_job(1, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_job(2, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_job(3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_job(3, 1'b0, 1'b0, 20, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    stream_job(2, 1'b0, 1'b0);
    check("push_a_entry", pe_load_en_act, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    reset = 1'b0;
    d0 = n_done;
    repeat (100) @(negedge clk);
    check("rst_no_done", n_done - d0, 0);
    check("rst_idle", busy, 0);
    run_job(2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (5) run_job($urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'b0, 0, 1'b1, 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
